// File: rtl/router_input_buffer.sv
// router_input_buffer
//   Input FIFO for one router port. Each message carries its destination
//   output index in its MSBs. The head of the queue drives a downstream demux
//   through out_msg/out_sel. The head is dequeued only when the selected
//   output's ready bit is set. A head whose destination does not exist is
//   dropped in a single cycle and latches route_err until reset.
//
//   Optional feature: define ROUTER_INBUF_BYPASS_EN to present an incoming
//   routable message combinationally when the queue is empty. If its output
//   is ready in the same cycle, the message passes through without being
//   stored.
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous, active-low
//   recv_msg   incoming message (destination in MSBs)
//   recv_val   recv_msg valid
//   recv_rdy   buffer can accept (not full)
//   out_msg    head-of-queue message
//   out_sel    head destination (demux select)
//   out_val    head valid and routable
//   out_rdy    per-output ready; only out_rdy[out_sel] is used
//   count      occupancy, 0..p_depth
//   route_err  sticky: an unroutable message was discarded
module router_input_buffer #(
    parameter int p_nbits    = 8,
    parameter int p_noutputs = 2,
    parameter int p_depth    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [p_nbits-1:0]            recv_msg,
    input  logic                          recv_val,
    output logic                          recv_rdy,
    output logic [p_nbits-1:0]            out_msg,
    output logic [$clog2(p_noutputs)-1:0] out_sel,
    output logic                          out_val,
    input  logic [p_noutputs-1:0]         out_rdy,
    output logic [$clog2(p_depth):0]      count,
    output logic                          route_err
);
    localparam int SEL_W = $clog2(p_noutputs);
    localparam int PTR_W = $clog2(p_depth);
    localparam int CNT_W = PTR_W + 1;
    localparam int NDST  = 1 << SEL_W;

    // One bit per encodable destination: set when that output exists.
    localparam logic [NDST-1:0] DST_OK = NDST'((64'd1 << p_noutputs) - 64'd1);

    logic [p_nbits-1:0] mem [p_depth];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   cnt;

    logic [p_nbits-1:0] head_msg;
    logic [SEL_W-1:0]   head_dst;
    logic [NDST-1:0]    rdy_pad;
    logic               not_empty, head_val, discard;
    logic               enq, deq, pass, push, pop;

    assign head_msg  = mem[rd_ptr];
    assign head_dst  = head_msg[p_nbits-1 -: SEL_W];
    // Pad ready so any encodable select indexes a real bit (missing outputs read 0).
    assign rdy_pad   = NDST'(out_rdy);
    assign not_empty = (cnt != '0);
    assign head_val  = not_empty && DST_OK[head_dst];
    assign discard   = not_empty && !DST_OK[head_dst];

    // No pass-through when full, even if the head leaves this cycle.
    assign recv_rdy  = (cnt != CNT_W'(p_depth));
    assign enq       = recv_val && recv_rdy;

`ifdef ROUTER_INBUF_BYPASS_EN
    logic [SEL_W-1:0] recv_dst;
    logic             bypass;

    assign recv_dst = recv_msg[p_nbits-1 -: SEL_W];
    // Gate with reset so nothing can complete while reset is held low.
    assign bypass   = reset && !not_empty && recv_val && DST_OK[recv_dst];
    assign out_msg  = bypass ? recv_msg : head_msg;
    assign out_sel  = bypass ? recv_dst : head_dst;
    assign out_val  = head_val || bypass;
    assign pass     = bypass && rdy_pad[recv_dst];
`else
    assign out_msg  = head_msg;
    assign out_sel  = head_dst;
    assign out_val  = head_val;
    assign pass     = 1'b0;
`endif

    assign deq   = out_val && rdy_pad[out_sel];
    // A bypass transfer only happens when empty, so it never pops storage.
    assign pop   = not_empty && (deq || discard);
    assign push  = enq && !pass;
    assign count = cnt;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= recv_msg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            route_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      cnt <= cnt + CNT_W'(1);
            else if (pop && !push) cnt <= cnt - CNT_W'(1);
            if (discard) route_err <= 1'b1;
        end
    end
endmodule
